// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Round-robin two-port (CPU / loader) arbiter and sequencer for a
//            single-port synchronous memory with fixed read latency.
//            Optional bus lock enabled by defining MEMARB_LOCK_EN.
// Revision : 1.0  initial release
// ============================================================================
module mem_arbiter #(
    parameter int AW      = 16,
    parameter int DW      = 8,
    parameter int MEM_LAT = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    req,
    input  logic [1:0]    we,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    input  logic [1:0]    lock,
    output logic [1:0]    ack,
    output logic [DW-1:0] rdata,
    output logic          busy,
    output logic          owner,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam logic [3:0] c_cnt_load = 4'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_ACK   = 2'd3
    } state_t;

    state_t        r_state;
    logic [3:0]    r_cnt;
    logic          r_last_grant;
    logic [1:0]    r_ack;
    logic [DW-1:0] r_rdata;
    logic          r_busy;
    logic          r_owner;
    logic          r_mem_en;
    logic          r_mem_we;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;

    logic [1:0]    w_req_eff;
    logic          w_grant;

    // A held lock on the last-granted port masks the other requester entirely.
    always_comb begin
        w_req_eff = req;
`ifdef MEMARB_LOCK_EN
        if (lock[r_last_grant]) begin
            w_req_eff = req & (r_last_grant ? 2'b10 : 2'b01);
        end
`endif
        w_grant = (w_req_eff == 2'b11) ? ~r_last_grant : w_req_eff[1];
    end

`ifndef MEMARB_LOCK_EN
    logic w_unused_lock;
    assign w_unused_lock = ^lock;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= 4'd0;
            r_last_grant <= 1'b1;
            r_ack        <= 2'b00;
            r_rdata      <= '0;
            r_busy       <= 1'b0;
            r_owner      <= 1'b0;
            r_mem_en     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
        end else begin
            r_mem_en <= 1'b0;
            r_ack    <= 2'b00;
            case (r_state)
                S_IDLE: begin
                    if (|w_req_eff) begin
                        r_owner      <= w_grant;
                        r_last_grant <= w_grant;
                        r_mem_addr   <= w_grant ? addr1 : addr0;
                        r_mem_wdata  <= w_grant ? wdata1 : wdata0;
                        r_mem_we     <= we[w_grant];
                        r_mem_en     <= 1'b1;
                        r_busy       <= 1'b1;
                        r_state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_cnt   <= c_cnt_load;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // Count reaches zero exactly MEM_LAT cycles after the strobe.
                    if (r_cnt == 4'd0) begin
                        if (!r_mem_we) begin
                            r_rdata <= mem_rdata;
                        end
                        r_ack   <= r_owner ? 2'b10 : 2'b01;
                        r_state <= S_ACK;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_ACK: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ack       = r_ack;
    assign rdata     = r_rdata;
    assign busy      = r_busy;
    assign owner     = r_owner;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule
`default_nettype wire
